unidade_pc: RTL and testbench

//   Program-counter unit, directly upstream of the data register bank.

---
 rtl/unidade_pc_if.sv | 34 +++
 rtl/unidade_pc.sv | 120 ++++++++++++
 tb/tb_unidade_pc.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_pc_if.sv
// Bus bundle between the program-counter unit and whoever drives its control
// inputs: the run/halt/stall requests, the redirect sources and the observed
// PC/status outputs.
interface unidade_pc_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              halt;
  logic              stall;
  logic              Jump;
  logic              Desvio;
  logic              cond;
  logic              Retorno;
  logic [ADDR_W-1:0] alvo;
  logic [ADDR_W-1:0] offset;
  logic [31:0]       jl;
  logic [ADDR_W-1:0] end_atual;
  logic              pc_valid;
  logic [1:0]        estado;
  logic [31:0]       instr_cnt;
  logic              wrapped;

  // Controller side: drives requests, observes the PC
  modport master (
    output start, halt, stall, Jump, Desvio, cond, Retorno, alvo, offset, jl,
    input  end_atual, pc_valid, estado, instr_cnt, wrapped
  );

  // PC unit side
  modport slave (
    input  start, halt, stall, Jump, Desvio, cond, Retorno, alvo, offset, jl,
    output end_atual, pc_valid, estado, instr_cnt, wrapped
  );
endinterface

// File: rtl/unidade_pc.sv
// Program-counter unit. Produces the current instruction address for the
// register bank and resolves the next PC: sequential, jump, taken branch or
// return through jl. A 4-state run/halt FSM gates fetching; an advance
// counter is kept for debug.
module unidade_pc #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                RET_WAIT   = 1
) (
  input logic         sys_clock,
  input logic         reset,
  unidade_pc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    WAIT_RET = 2'b10,
    HALT     = 2'b11
  } estado_t;

  estado_t           estado_q;
  logic [ADDR_W-1:0] end_atual_q;
  logic              pc_valid_q;
  logic [31:0]       instr_cnt_q;
  logic              wrapped_q;
  logic [2:0]        wait_q;

  logic [ADDR_W-1:0] pcSeq;
  logic [ADDR_W-1:0] pcTaken;
  logic              pcAtTop;
  logic [31:0]       cntInc;

  // Candidate next addresses and the saturating advance count
  always_comb begin
    pcSeq   = end_atual_q + ADDR_W'(1);
    pcTaken = end_atual_q + ADDR_W'(1) + bus.offset;
    pcAtTop = (end_atual_q == '1);
    cntInc  = (instr_cnt_q == 32'hFFFF_FFFF) ? instr_cnt_q : instr_cnt_q + 32'd1;
  end

  // Run/halt FSM with all outputs registered alongside the state
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      estado_q    <= IDLE;
      end_atual_q <= RESET_ADDR;
      pc_valid_q  <= 1'b0;
      instr_cnt_q <= '0;
      wrapped_q   <= 1'b0;
      wait_q      <= '0;
    end else begin
      case (estado_q)
        IDLE: begin
          if (bus.start) begin
            estado_q   <= RUN;
            pc_valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.halt) begin
            estado_q   <= HALT;
            pc_valid_q <= 1'b0;
          end else if (bus.stall) begin
            estado_q <= RUN;
          end else if (bus.Retorno) begin
            estado_q   <= WAIT_RET;
            pc_valid_q <= 1'b0;
            wait_q     <= 3'(RET_WAIT);
          end else if (bus.Jump) begin
            end_atual_q <= bus.alvo;
            instr_cnt_q <= cntInc;
          end else if (bus.Desvio && bus.cond) begin
            end_atual_q <= pcTaken;
            instr_cnt_q <= cntInc;
          end else begin
            end_atual_q <= pcSeq;
            instr_cnt_q <= cntInc;
            if (pcAtTop) begin
              wrapped_q <= 1'b1;
            end
          end
        end
        WAIT_RET: begin
          if (bus.halt) begin
            estado_q <= HALT;
            wait_q   <= '0;
          end else if (wait_q == 3'd1) begin
            estado_q    <= RUN;
            pc_valid_q  <= 1'b1;
            end_atual_q <= bus.jl[ADDR_W-1:0];
            instr_cnt_q <= cntInc;
            wait_q      <= '0;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        HALT: begin
          if (bus.start && !bus.halt) begin
            estado_q   <= RUN;
            pc_valid_q <= 1'b1;
          end
        end
        default: begin
          estado_q   <= IDLE;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs come straight from the registers
  always_comb begin
    bus.end_atual = end_atual_q;
    bus.pc_valid  = pc_valid_q;
    bus.estado    = estado_q;
    bus.instr_cnt = instr_cnt_q;
    bus.wrapped   = wrapped_q;
  end

endmodule

// File: tb/tb_unidade_pc.sv
// Testbench for unidade_pc: reset behaviour, a table of single-cycle
// decisions, hand-written multi-cycle sequences (return, wrap, halt/resume,
// reset during WAIT_RET, stall) and a randomized run against a
// behavioural model.
module tb_unidade_pc;

  localparam int ADDR_W   = 16;
  localparam int RET_WAIT = 1;

  typedef struct packed {
    logic        start;
    logic        halt;
    logic        stall;
    logic        jump;
    logic        desvio;
    logic        cond;
    logic        retorno;
    logic [15:0] alvo;
    logic [15:0] offset;
    logic [31:0] jl;
  } stim_t;

  typedef struct {
    stim_t       in;
    logic [15:0] expPc;
    logic [1:0]  expEstado;
    logic        expValid;
    logic [31:0] expCnt;
  } vec_t;

  logic sys_clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state: mode uses the estado encoding
  int          mMode;
  int unsigned mPc;
  longint      mCnt;
  bit          mWrap;
  int          mWait;

  // Free-running clock
  always #5 sys_clock = ~sys_clock;

  unidade_pc_if #(.ADDR_W(ADDR_W)) bus ();

  unidade_pc #(
    .ADDR_W    (ADDR_W),
    .RESET_ADDR(16'h0000),
    .RET_WAIT  (RET_WAIT)
  ) dut (
    .sys_clock(sys_clock),
    .reset    (reset),
    .bus      (bus)
  );

  function automatic stim_t mk(bit st, bit h, bit sl, bit j, bit d, bit c, bit r,
                               logic [15:0] a, logic [15:0] o, logic [31:0] l);
    stim_t s;
    s.start = st; s.halt = h; s.stall = sl; s.jump = j; s.desvio = d;
    s.cond = c; s.retorno = r; s.alvo = a; s.offset = o; s.jl = l;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 32'h0);
  endfunction

  task automatic driveInputs(input stim_t s);
    bus.start   = s.start;
    bus.halt    = s.halt;
    bus.stall   = s.stall;
    bus.Jump    = s.jump;
    bus.Desvio  = s.desvio;
    bus.cond    = s.cond;
    bus.Retorno = s.retorno;
    bus.alvo    = s.alvo;
    bus.offset  = s.offset;
    bus.jl      = s.jl;
  endtask

  task automatic applyStimulus(input stim_t s);
    driveInputs(s);
    @(posedge sys_clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [15:0] pc, input logic [1:0] st,
                          input logic v, input logic [31:0] cnt, input logic w);
    checkOutput({tag, " end_atual"}, 32'(bus.end_atual), 32'(pc));
    checkOutput({tag, " estado"},    32'(bus.estado),    32'(st));
    checkOutput({tag, " pc_valid"},  32'(bus.pc_valid),  32'(v));
    checkOutput({tag, " instr_cnt"}, bus.instr_cnt,      cnt);
    checkOutput({tag, " wrapped"},   32'(bus.wrapped),   32'(w));
  endtask

  task automatic modelReset();
    mMode = 0; mPc = 0; mCnt = 0; mWrap = 0; mWait = 0;
  endtask

  task automatic modelAdvance(input int unsigned newPc);
    mPc = newPc % 65536;
    if (mCnt < 64'h0000_0000_FFFF_FFFF) mCnt = mCnt + 1;
  endtask

  // One clock of the unit, straight from the behavioural rules
  task automatic modelStep(input stim_t s);
    case (mMode)
      0: if (s.start) mMode = 1;
      1: begin
        if (s.halt) mMode = 3;
        else if (s.stall) mMode = 1;
        else if (s.retorno) begin
          mMode = 2;
          mWait = RET_WAIT;
        end else if (s.jump) modelAdvance(s.alvo);
        else if (s.desvio && s.cond) modelAdvance(mPc + 1 + s.offset);
        else begin
          if (mPc == 65535) mWrap = 1;
          modelAdvance(mPc + 1);
        end
      end
      2: begin
        if (s.halt) mMode = 3;
        else begin
          mWait = mWait - 1;
          if (mWait == 0) begin
            modelAdvance(s.jl % 65536);
            mMode = 1;
          end
        end
      end
      default: if (s.start && !s.halt) mMode = 1;
    endcase
  endtask

  initial begin
    vec_t  tbl[10];
    stim_t s;

    // Reset state
    reset = 1'b1;
    driveInputs(idle());
    #12;
    checkAll("reset", 16'h0000, 2'b00, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;

    // Start, run two steps, reset mid-run, restart and count five steps
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 32'h0));
    checkAll("start", 16'h0000, 2'b01, 1'b1, 32'd0, 1'b0);
    applyStimulus(idle());
    applyStimulus(idle());
    checkOutput("run2 end_atual", 32'(bus.end_atual), 32'h2);
    #2 reset = 1'b1;
    #1;
    checkAll("midrun reset", 16'h0000, 2'b00, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 32'h0));
    checkOutput("restart end_atual", 32'(bus.end_atual), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(idle());
      checkOutput($sformatf("seq%0d end_atual", i), 32'(bus.end_atual), 32'(i));
    end
    checkOutput("seq instr_cnt", bus.instr_cnt, 32'd5);

    // Single-cycle decision table, starting at end_atual=5, instr_cnt=5
    tbl[0] = '{mk(0,0,0,1,0,0,0,16'h0010,16'h0000,0), 16'h0010, 2'b01, 1'b1, 32'd6};
    tbl[1] = '{mk(0,0,0,0,1,1,0,16'h0000,16'hFFFC,0), 16'h000D, 2'b01, 1'b1, 32'd7};
    tbl[2] = '{mk(0,0,0,1,0,0,0,16'h0010,16'h0000,0), 16'h0010, 2'b01, 1'b1, 32'd8};
    tbl[3] = '{mk(0,0,0,0,1,0,0,16'h0000,16'hFFFC,0), 16'h0011, 2'b01, 1'b1, 32'd9};
    tbl[4] = '{mk(0,0,0,1,1,1,0,16'h0100,16'h0004,0), 16'h0100, 2'b01, 1'b1, 32'd10};
    tbl[5] = '{mk(0,0,1,0,0,0,0,16'h0000,16'h0000,0), 16'h0100, 2'b01, 1'b1, 32'd10};
    tbl[6] = '{mk(0,0,1,1,0,0,0,16'h0555,16'h0000,0), 16'h0100, 2'b01, 1'b1, 32'd10};
    tbl[7] = '{mk(0,0,0,0,0,0,0,16'h0000,16'h0000,0), 16'h0101, 2'b01, 1'b1, 32'd11};
    tbl[8] = '{mk(0,1,0,1,0,0,0,16'h0777,16'h0000,0), 16'h0101, 2'b11, 1'b0, 32'd11};
    tbl[9] = '{mk(1,1,0,1,0,0,0,16'h0777,16'h0000,0), 16'h0101, 2'b11, 1'b0, 32'd11};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].in);
      checkAll($sformatf("vec%0d", i), tbl[i].expPc, tbl[i].expEstado,
               tbl[i].expValid, tbl[i].expCnt, 1'b0);
    end

    // Resume from HALT at the held address
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 32'h0));
    checkAll("resume", 16'h0101, 2'b01, 1'b1, 32'd11, 1'b0);

    // Return: one cycle in WAIT_RET, Jump there is ignored, then jl is taken
    applyStimulus(mk(0, 0, 0, 1, 0, 0, 0, 16'h0020, 16'h0, 32'h0));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 32'h0000_0042));
    checkAll("ret wait", 16'h0020, 2'b10, 1'b0, 32'd12, 1'b0);
    applyStimulus(mk(0, 0, 1, 1, 1, 1, 1, 16'h0333, 16'h0009, 32'h0000_0042));
    checkAll("ret done", 16'h0042, 2'b01, 1'b1, 32'd13, 1'b0);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 32'hDEAD_0077));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 32'hDEAD_0077));
    checkAll("ret upper", 16'h0077, 2'b01, 1'b1, 32'd14, 1'b0);

    // Halt during WAIT_RET abandons the return
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 32'h0000_0099));
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 32'h0000_0099));
    checkAll("ret halt", 16'h0077, 2'b11, 1'b0, 32'd14, 1'b0);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 32'h0));

    // Sequential wrap from all-ones sets the sticky flag; halt/resume keep it
    applyStimulus(mk(0, 0, 0, 1, 0, 0, 0, 16'hFFFF, 16'h0, 32'h0));
    checkAll("at top", 16'hFFFF, 2'b01, 1'b1, 32'd15, 1'b0);
    applyStimulus(idle());
    checkAll("wrap", 16'h0000, 2'b01, 1'b1, 32'd16, 1'b1);
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 32'h0));
    applyStimulus(idle());
    checkAll("halted", 16'h0000, 2'b11, 1'b0, 32'd16, 1'b1);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 32'h0));
    checkAll("wrap resume", 16'h0000, 2'b01, 1'b1, 32'd16, 1'b1);

    // Asynchronous reset while waiting for a return
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 32'h0000_0055));
    checkOutput("pre-reset estado", 32'(bus.estado), 32'h2);
    #2 reset = 1'b1;
    #1;
    checkAll("reset in wait", 16'h0000, 2'b00, 1'b0, 32'd0, 1'b0);
    #1 reset = 1'b0;

    // Three stalled cycles freeze address and count
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 32'h0));
    applyStimulus(idle());
    applyStimulus(idle());
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(0, 0, 1, 0, 1, 1, 0, 16'h0, 16'h0008, 32'h0));
      checkAll($sformatf("stall%0d", i), 16'h0002, 2'b01, 1'b1, 32'd2, 1'b0);
    end
    applyStimulus(idle());
    checkOutput("post-stall end_atual", 32'(bus.end_atual), 32'h3);

    // Randomized run against the behavioural model
    reset = 1'b1;
    driveInputs(idle());
    #3;
    reset = 1'b0;
    modelReset();
    for (int i = 0; i < 400; i++) begin
      s = idle();
      s.start   = ($urandom_range(0, 3) == 0);
      s.halt    = ($urandom_range(0, 15) == 0);
      s.stall   = ($urandom_range(0, 5) == 0);
      s.retorno = ($urandom_range(0, 7) == 0);
      s.jump    = ($urandom_range(0, 5) == 0);
      s.desvio  = ($urandom_range(0, 2) == 0);
      s.cond    = 1'($urandom_range(0, 1));
      s.alvo    = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      s.offset  = 16'($urandom);
      s.jl      = $urandom;
      modelStep(s);
      applyStimulus(s);
      checkAll($sformatf("rand%0d", i), 16'(mPc), 2'(mMode), (mMode == 1),
               32'(mCnt), mWrap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
